// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: datapath widths, issue FSM states and the
// operand record passed from operand fetch to the reservation stations.
package cpu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ROB_W = 5;
    localparam int unsigned RS_W  = 3;
    localparam int unsigned RS_N  = 1 << RS_W;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OP_W  = 7;
    localparam int unsigned F7_W  = 7;
    localparam int unsigned F3_W  = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ     = 2'd1,
        DISPATCH = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0]  v;
        logic [ROB_W-1:0] q;
        logic             r;
    } operand_t;

    typedef struct packed {
        logic [RS_W-1:0]  rs_id;
        logic [ROB_W-1:0] rob_id;
        logic [OP_W-1:0]  op;
        logic [F7_W-1:0]  funct7;
        logic [F3_W-1:0]  funct3;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             use1;
        logic             use2;
    } instr_t;

    function automatic logic cdb_hit(input logic             valid,
                                     input logic [ROB_W-1:0] tag,
                                     input logic [ROB_W-1:0] q);
        return valid && (tag == q);
    endfunction

endpackage

// File: rtl/operand_resolve.sv
// Resolves one source operand: priority mux over x0/unused, regfile value and
// CDB bypass while reading, and CDB wake-up of a held pending operand otherwise.
module operand_resolve
    import cpu_pkg::*;
(
    input  logic             read_i,
    input  logic             use_i,
    input  logic [REG_W-1:0] idx_i,
    input  logic             rdy_i,
    input  logic [XLEN-1:0]  data_i,
    input  logic [ROB_W-1:0] rid_i,
    input  operand_t         held_i,
    input  logic             cdb_valid_i,
    input  logic [ROB_W-1:0] cdb_rob_i,
    input  logic [XLEN-1:0]  cdb_data_i,
    output operand_t         res_o
);

    always_comb begin
        res_o = held_i;
        if (read_i) begin
            if (!use_i || idx_i == '0) begin
                res_o = '{v: '0, q: '0, r: 1'b1};
            end else if (rdy_i) begin
                res_o = '{v: data_i, q: '0, r: 1'b1};
            end else if (cdb_hit(cdb_valid_i, cdb_rob_i, rid_i)) begin
                res_o = '{v: cdb_data_i, q: '0, r: 1'b1};
            end else begin
                res_o = '{v: '0, q: rid_i, r: 1'b0};
            end
        end else if (!held_i.r && cdb_hit(cdb_valid_i, cdb_rob_i, held_i.q)) begin
            // Already-ready operands never look at the CDB again.
            res_o.r = 1'b1;
            res_o.v = cdb_data_i;
        end
    end

endmodule

// File: rtl/operand_issue_ctrl.sv
// Operand-fetch sequencer: accepts a decoded instruction, reads both source
// operands with CDB bypass, then holds it until the target RS has a free slot.
module operand_issue_ctrl
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [RS_W-1:0]   in_rs_id_i,
    input  logic [ROB_W-1:0]  in_rob_id_i,
    input  logic [OP_W-1:0]   in_op_i,
    input  logic [F7_W-1:0]   in_funct7_i,
    input  logic [F3_W-1:0]   in_funct3_i,
    input  logic [XLEN-1:0]   in_imm_i,
    input  logic [XLEN-1:0]   in_pc_i,
    input  logic [REG_W-1:0]  in_rs1_i,
    input  logic [REG_W-1:0]  in_rs2_i,
    input  logic              in_use1_i,
    input  logic              in_use2_i,
    output logic              re1_o,
    output logic              re2_o,
    output logic [REG_W-1:0]  addr1_o,
    output logic [REG_W-1:0]  addr2_o,
    input  logic              rdy1_i,
    input  logic              rdy2_i,
    input  logic [XLEN-1:0]   data1_i,
    input  logic [XLEN-1:0]   data2_i,
    input  logic [ROB_W-1:0]  rid1_i,
    input  logic [ROB_W-1:0]  rid2_i,
    input  logic [RS_N-1:0]   rs_free_i,
    input  logic              cdb_valid_i,
    input  logic [ROB_W-1:0]  cdb_rob_i,
    input  logic [XLEN-1:0]   cdb_data_i,
    output logic              out_valid_o,
    output logic [RS_W-1:0]   out_rs_id_o,
    output logic [ROB_W-1:0]  out_rob_id_o,
    output logic [OP_W-1:0]   out_op_o,
    output logic [F7_W-1:0]   out_funct7_o,
    output logic [F3_W-1:0]   out_funct3_o,
    output logic [XLEN-1:0]   out_imm_o,
    output logic [XLEN-1:0]   out_pc_o,
    output logic [XLEN-1:0]   out_v1_o,
    output logic [XLEN-1:0]   out_v2_o,
    output logic [ROB_W-1:0]  out_q1_o,
    output logic [ROB_W-1:0]  out_q2_o,
    output logic              out_r1_o,
    output logic              out_r2_o
);

    state_e   state_q, state_d;
    instr_t   ins_q, ins_d, new_ins;
    operand_t opnd1_q, opnd1_d, opnd2_q, opnd2_d;
    operand_t res1, res2, op1_out, op2_out;
    logic     st_read, st_disp, disp, accept;

    assign st_read = (state_q == READ);
    assign st_disp = (state_q == DISPATCH);
    assign disp    = st_disp & rs_free_i[ins_q.rs_id] & ~flush_i;

    // Ready is held low while reset is asserted and during a flush cycle.
    assign in_ready_o = rst & ~flush_i & ((state_q == IDLE) | disp);
    assign accept     = in_valid_i & in_ready_o;

    assign new_ins = '{rs_id: in_rs_id_i, rob_id: in_rob_id_i, op: in_op_i,
                       funct7: in_funct7_i, funct3: in_funct3_i, imm: in_imm_i,
                       pc: in_pc_i, rs1: in_rs1_i, rs2: in_rs2_i,
                       use1: in_use1_i, use2: in_use2_i};

    assign re1_o   = st_read & ins_q.use1;
    assign re2_o   = st_read & ins_q.use2;
    assign addr1_o = re1_o ? ins_q.rs1 : '0;
    assign addr2_o = re2_o ? ins_q.rs2 : '0;

    operand_resolve u_res1 (
        .read_i      (st_read),
        .use_i       (ins_q.use1),
        .idx_i       (ins_q.rs1),
        .rdy_i       (rdy1_i),
        .data_i      (data1_i),
        .rid_i       (rid1_i),
        .held_i      (opnd1_q),
        .cdb_valid_i (cdb_valid_i),
        .cdb_rob_i   (cdb_rob_i),
        .cdb_data_i  (cdb_data_i),
        .res_o       (res1)
    );

    operand_resolve u_res2 (
        .read_i      (st_read),
        .use_i       (ins_q.use2),
        .idx_i       (ins_q.rs2),
        .rdy_i       (rdy2_i),
        .data_i      (data2_i),
        .rid_i       (rid2_i),
        .held_i      (opnd2_q),
        .cdb_valid_i (cdb_valid_i),
        .cdb_rob_i   (cdb_rob_i),
        .cdb_data_i  (cdb_data_i),
        .res_o       (res2)
    );

    always_comb begin
        state_d = state_q;
        ins_d   = ins_q;
        opnd1_d = opnd1_q;
        opnd2_d = opnd2_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = READ;
            end
            READ: begin
                state_d = DISPATCH;
                opnd1_d = res1;
                opnd2_d = res2;
            end
            DISPATCH: begin
                opnd1_d = res1;
                opnd2_d = res2;
                if (disp) state_d = accept ? READ : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) ins_d = new_ins;
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ins_q   <= '0;
            opnd1_q <= '0;
            opnd2_q <= '0;
        end else begin
            state_q <= state_d;
            ins_q   <= ins_d;
            opnd1_q <= opnd1_d;
            opnd2_q <= opnd2_d;
        end
    end

    // Same-cycle CDB wake-up is visible on the dispatch bus.
    assign op1_out = st_disp ? res1 : opnd1_q;
    assign op2_out = st_disp ? res2 : opnd2_q;

    assign out_valid_o  = disp;
    assign out_rs_id_o  = ins_q.rs_id;
    assign out_rob_id_o = ins_q.rob_id;
    assign out_op_o     = ins_q.op;
    assign out_funct7_o = ins_q.funct7;
    assign out_funct3_o = ins_q.funct3;
    assign out_imm_o    = ins_q.imm;
    assign out_pc_o     = ins_q.pc;
    assign out_v1_o     = op1_out.v;
    assign out_v2_o     = op2_out.v;
    assign out_q1_o     = op1_out.q;
    assign out_q2_o     = op2_out.q;
    assign out_r1_o     = op1_out.r;
    assign out_r2_o     = op2_out.r;

endmodule

// File: doc/operand_issue_ctrl.md
# operand_issue_ctrl

Sequencer for the operand-fetch stage. It accepts one decoded instruction at a time from decode and drives the two register-file read ports. It resolves each source operand to a value or a ROB tag, with common-data-bus (CDB) bypass, and holds the instruction until its target reservation station (RS) has a free slot. It sits between decode and the RS array, replacing the fixed always-read port drive with a handshaked, flush-aware FSM.

## Interface
- XLEN, 32, data width
- ROB_W, 5, ROB tag width
- RS_W, 3, RS id width (2**RS_W stations)
- clk  in  1  clock, rising edge
- rst  in  1  one clock; reset is asynchronous and active-low (0 = reset)
- flush_i  in  1  mispredict flush, synchronous
- in_valid_i / in_ready_o  in/out  1  decode handshake
- in_rs_id_i  in  RS_W  target RS
- in_rob_id_i  in  ROB_W  destination ROB tag
- in_op_i, in_funct7_i, in_funct3_i  in  7/7/3  opcode fields
- in_imm_i, in_pc_i  in  XLEN  immediate, PC
- in_rs1_i, in_rs2_i  in  5  source register indices
- in_use1_i, in_use2_i  in  1  source actually read
- re1_o, re2_o  out  1  regfile read enables
- addr1_o, addr2_o  out  5  regfile read addresses
- rdy1_i, rdy2_i  in  1  regfile value valid (0 = pending, renamed)
- data1_i, data2_i  in  XLEN  regfile values
- rid1_i, rid2_i  in  ROB_W  producing ROB tag when pending
- rs_free_i  in  2**RS_W  per-station free-slot flags
- cdb_valid_i, cdb_rob_i, cdb_data_i  in  1/ROB_W/XLEN  result broadcast
- out_valid_o  out  1  dispatch strobe to RS
- out_rs_id_o, out_rob_id_o, out_op_o, out_funct7_o, out_funct3_o, out_imm_o, out_pc_o  out  latched fields
- out_v1_o, out_v2_o  out  XLEN  operand values
- out_q1_o, out_q2_o  out  ROB_W  operand tags
- out_r1_o, out_r2_o  out  1  operand ready

## Operation
- States: IDLE, READ, DISPATCH.
- IDLE
  - in_ready_o=1.
  - On in_valid_i, latch all in_* fields and go to READ.
- READ
  - re1_o=in_use1 latched; addr1_o=rs1 latched, else 0. Port 2 works the same way.
  - Regfile responds combinationally in the same cycle.
  - Per operand, evaluated in priority order:
    - unused, or index 0: r=1, v=0, q=0.
    - rdy=1: r=1, v=data.
    - cdb_valid_i and cdb_rob_i==rid: r=1, v=cdb_data_i.
    - otherwise: r=0, q=rid.
  - Always go to DISPATCH.
- DISPATCH
  - Each cycle, any operand with r=0 and q==cdb_rob_i under cdb_valid_i is updated to r=1, v=cdb_data_i at the clock edge.
  - out_* also reflect this bypass combinationally in the same cycle, so an RS capturing on out_valid_o never misses the broadcast.
  - out_valid_o = rs_free_i[rs_id] & ~flush_i.
  - When out_valid_o=1, in_ready_o=1. A new instruction accepted that cycle goes to READ; otherwise go to IDLE.
  - When out_valid_o=0, stay in DISPATCH (stall) with in_ready_o=0.
- re*_o=0 and addr*_o=0 outside READ.
- Flush
  - Any state goes to IDLE next edge; latched instruction dropped.
  - in_ready_o=0 and out_valid_o=0 during the flush cycle.
- Reset
  - State IDLE; all latched registers 0; all outputs 0 except in_ready_o, which is 1 after reset release.
  - Reset mid-stall discards the instruction.

## Timing
- Accept at edge T: READ during cycle T+1, DISPATCH from T+2.
- out_valid_o earliest in cycle T+2: 2-cycle latency.
- Sustained throughput: 1 instruction per 2 cycles when RS is free.
- Back-to-back: accept in DISPATCH cycle overlaps with dispatch; no bubble beyond READ.
- Simultaneous flush and in_valid_i: flush wins, nothing accepted.
- CDB match in the same cycle as dispatch: bypassed value dispatched with r=1.
- CDB tag matching a ready operand: ignored.
- Stall length unbounded; operands keep updating from CDB throughout.

## Structure
- Shared package `cpu_pkg`:
  - XLEN / ROB_W / RS_W constants.
  - State encoding typedef (IDLE=0, READ=1, DISPATCH=2).
  - Operand struct {v, q, r}, shared with the RS.
- One sub-module `operand_resolve`: per-operand priority mux with CDB bypass, instantiated twice in READ and reused in DISPATCH.

## Test plan
- Ready operands, regfile x1=0x11, x2=0x22 ready, RS 3 free: accept at T -> out_valid_o at T+2 with v1=0x11, v2=0x22, r1=r2=1.
- Pending rs1 (rid=7), CDB tag 7 data 0xAB in READ cycle: dispatch with r1=1, v1=0xAB.
- RS 3 busy for 4 cycles, CDB tag 5 0xCC during stall on q2=5: out_valid_o held low 4 cycles, then dispatch with r2=1, v2=0xCC; in_ready_o low throughout.
- in_use2=0, rs1=x0: re2_o=0, addr1_o=0 in READ; out r1=r2=1, v1=v2=0.
- flush_i asserted in DISPATCH with in_valid_i=1: no out_valid_o, next state IDLE, new instruction not accepted.
- rst asserted during stall: outputs 0 immediately; after release in_ready_o=1 and no stale dispatch.
